port_response_reorder: RTL and testbench

//   Per-port in-order response collector that sits downstream of the four memory

---
 rtl/port_response_reorder.sv | 125 ++++++++++++
 tb/tb_port_response_reorder.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_response_reorder.sv
// Per-port in-order response collector: allocates request tags, captures
// out-of-order bank read data and releases responses in issue order.
module port_response_reorder #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned TAG_W     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_valid,
  input  logic                          issue_wen,
  output logic                          issue_ready,
  output logic [TAG_W-1:0]              issue_tag,
  input  logic [NUM_BANKS-1:0]          bank_valid,
  input  logic [NUM_BANKS*TAG_W-1:0]    bank_tag,
  input  logic [NUM_BANKS*DATA_W-1:0]   bank_data,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [TAG_W-1:0]              resp_tag,
  output logic [DATA_W-1:0]             resp_data,
  output logic                          resp_wen,
  output logic [TAG_W:0]                outstanding,
  output logic                          err_sticky,
  input  logic                          err_clear
);

  localparam int unsigned DEPTH  = 1 << TAG_W;
  localparam int unsigned PTR_W  = TAG_W + 1;
  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [DEPTH-1:0]  alloc;
  logic [DEPTH-1:0]  done;
  logic [DEPTH-1:0]  wen;
  logic [DATA_W-1:0] data [DEPTH];

  logic [TAG_W-1:0]  head_idx;
  logic [TAG_W-1:0]  tail_idx;
  logic              issue_fire;
  logic              retire_fire;

  logic [DEPTH-1:0]  cap_en;
  logic [DATA_W-1:0] cap_data [DEPTH];
  logic [DEPTH-1:0]  claimed;
  logic [TAG_W-1:0]  tag_b;
  logic              cap_err;

  assign head_idx    = head[TAG_W-1:0];
  assign tail_idx    = tail[TAG_W-1:0];
  assign outstanding = tail - head;
  assign issue_ready = (outstanding != PTR_W'(DEPTH));
  assign issue_tag   = tail_idx;
  assign issue_fire  = issue_valid & issue_ready;

  // Head-of-line release; idle outputs are forced to zero
  assign resp_valid  = alloc[head_idx] & done[head_idx];
  assign resp_tag    = head_idx;
  assign resp_data   = resp_valid ? data[head_idx] : '0;
  assign resp_wen    = resp_valid & wen[head_idx];
  assign retire_fire = resp_valid & resp_ready;

  // Merge bank responses; lowest bank wins a duplicate tag, the rest are errors
  always_comb begin
    cap_en  = '0;
    claimed = '0;
    cap_err = 1'b0;
    tag_b   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cap_data[TAG_W'(i)] = '0;
    end
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank_valid[BANK_W'(b)]) begin
        tag_b = bank_tag[b*TAG_W +: TAG_W];
        if (claimed[tag_b]) begin
          cap_err = 1'b1;
        end else begin
          claimed[tag_b] = 1'b1;
          if (alloc[tag_b] & ~done[tag_b] & ~wen[tag_b]) begin
            cap_en[tag_b]   = 1'b1;
            cap_data[tag_b] = bank_data[b*DATA_W +: DATA_W];
          end else begin
            cap_err = 1'b1;
          end
        end
      end
    end
  end

  // Capture, retire and issue touch distinct entries, so all apply together
  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      alloc      <= '0;
      done       <= '0;
      wen        <= '0;
      err_sticky <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data[TAG_W'(i)] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (cap_en[TAG_W'(i)]) begin
          done[TAG_W'(i)] <= 1'b1;
          data[TAG_W'(i)] <= cap_data[TAG_W'(i)];
        end
      end
      if (retire_fire) begin
        alloc[head_idx] <= 1'b0;
        done[head_idx]  <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      if (issue_fire) begin
        alloc[tail_idx] <= 1'b1;
        wen[tail_idx]   <= issue_wen;
        done[tail_idx]  <= issue_wen;
        data[tail_idx]  <= '0;
        tail            <= tail + PTR_W'(1);
      end
      err_sticky <= cap_err | (err_sticky & ~err_clear);
    end
  end

endmodule

// File: tb/tb_port_response_reorder.sv
// Self-checking bench for port_response_reorder: directed scenarios plus
// randomized traffic against a queue-based in-order reference model.
module tb_port_response_reorder;

  localparam int NB = 4;
  localparam int DW = 16;
  localparam int TW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              issue_valid;
  logic              issue_wen;
  logic              issue_ready;
  logic [TW-1:0]     issue_tag;
  logic [NB-1:0]     bank_valid;
  logic [NB*TW-1:0]  bank_tag;
  logic [NB*DW-1:0]  bank_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [TW-1:0]     resp_tag;
  logic [DW-1:0]     resp_data;
  logic              resp_wen;
  logic [TW:0]       outstanding;
  logic              err_sticky;
  logic              err_clear;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: issue-order queue of tags plus per-tag completion info
  int            ord_q[$];
  bit            m_done [4];
  bit            m_wen  [4];
  logic [DW-1:0] m_data [4];
  int            m_tail_tag;
  int            m_head_tag;
  bit            m_err;

  always #5 clk = ~clk;

  port_response_reorder #(.NUM_BANKS(NB), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_ready(issue_ready), .issue_tag(issue_tag),
    .bank_valid(bank_valid), .bank_tag(bank_tag), .bank_data(bank_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
    .resp_data(resp_data), .resp_wen(resp_wen),
    .outstanding(outstanding), .err_sticky(err_sticky), .err_clear(err_clear)
  );

  function automatic bit in_q(int t);
    foreach (ord_q[i]) if (ord_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_inputs();
    reset = 1'b0; issue_valid = 1'b0; issue_wen = 1'b0;
    bank_valid = '0; bank_tag = '0; bank_data = '0; err_clear = 1'b0;
  endtask

  task automatic set_bank(int b, int t, logic [DW-1:0] d);
    bank_valid[b]         = 1'b1;
    bank_tag[b*TW +: TW]  = TW'(t);
    bank_data[b*DW +: DW] = d;
  endtask

  // One clock: model the cycle from the current inputs, then advance
  task automatic tick();
    bit            seen [4];
    bit            cap  [4];
    logic [DW-1:0] capd [4];
    bit            nerr;
    bit            do_ret;
    bit            do_iss;
    int            t;
    nerr = 1'b0;
    for (int i = 0; i < 4; i++) begin seen[i] = 1'b0; cap[i] = 1'b0; capd[i] = '0; end
    do_ret = resp_ready && ord_q.size() > 0 && m_done[ord_q[0]];
    do_iss = issue_valid && ord_q.size() != 4;
    for (int b = 0; b < NB; b++) begin
      if (bank_valid[b]) begin
        t = int'(bank_tag[b*TW +: TW]);
        if (seen[t]) nerr = 1'b1;
        else begin
          seen[t] = 1'b1;
          if (in_q(t) && !m_done[t] && !m_wen[t]) begin
            cap[t] = 1'b1; capd[t] = bank_data[b*DW +: DW];
          end else nerr = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      ord_q.delete();
      for (int i = 0; i < 4; i++) begin m_done[i] = 1'b0; m_wen[i] = 1'b0; m_data[i] = '0; end
      m_tail_tag = 0; m_head_tag = 0; m_err = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) if (cap[i]) begin m_done[i] = 1'b1; m_data[i] = capd[i]; end
      if (do_ret) begin
        m_done[ord_q[0]] = 1'b0;
        void'(ord_q.pop_front());
        m_head_tag = (m_head_tag + 1) % 4;
      end
      if (do_iss) begin
        ord_q.push_back(m_tail_tag);
        m_wen[m_tail_tag]  = issue_wen;
        m_done[m_tail_tag] = issue_wen;
        m_data[m_tail_tag] = '0;
        m_tail_tag = (m_tail_tag + 1) % 4;
      end
      m_err = nerr | (m_err & !err_clear);
    end
  endtask

  task automatic test_reset();
    clear_inputs(); resp_ready = 1'b1; reset = 1'b1;
    tick(); tick();
    clear_inputs();
    tick();
    n_checks++;
    if ({issue_ready, issue_tag, outstanding} !== {1'b1, 2'd0, 3'd0}) begin
      n_fail++; $display("FAIL reset_issue: got ready=%b tag=%0d out=%0d, expected 1 0 0", issue_ready, issue_tag, outstanding);
    end
    n_checks++;
    if ({resp_valid, resp_tag, resp_data, resp_wen, err_sticky} !== {1'b0, 2'd0, 16'h0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_resp: got v=%b tag=%0d data=%h wen=%b err=%b, expected all 0", resp_valid, resp_tag, resp_data, resp_wen, err_sticky);
    end
  endtask

  task automatic test_ooo_reads();
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (issue_tag !== TW'(i)) begin
        n_fail++; $display("FAIL ooo_issue_tag: got %0d expected %0d", issue_tag, i);
      end
      issue_valid = 1'b1; issue_wen = 1'b0;
      tick();
    end
    clear_inputs();
    n_checks++;
    if ({issue_ready, outstanding} !== {1'b0, 3'd4}) begin
      n_fail++; $display("FAIL ooo_full: got ready=%b out=%0d expected 0 4", issue_ready, outstanding);
    end
    set_bank(2, 2, 16'hBEEF); tick(); clear_inputs();
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL ooo_no_early: got resp_valid=%b expected 0", resp_valid);
    end
    set_bank(0, 0, 16'h1234); set_bank(3, 1, 16'h5678); tick(); clear_inputs();
    n_checks++;
    if ({resp_valid, resp_tag, resp_data, resp_wen} !== {1'b1, 2'd0, 16'h1234, 1'b0}) begin
      n_fail++; $display("FAIL ooo_resp0: got v=%b tag=%0d data=%h expected 1 0 1234", resp_valid, resp_tag, resp_data);
    end
    tick();
    n_checks++;
    if ({resp_valid, resp_tag, resp_data} !== {1'b1, 2'd1, 16'h5678}) begin
      n_fail++; $display("FAIL ooo_resp1: got v=%b tag=%0d data=%h expected 1 1 5678", resp_valid, resp_tag, resp_data);
    end
    tick();
    n_checks++;
    if ({resp_valid, resp_tag, resp_data} !== {1'b1, 2'd2, 16'hBEEF}) begin
      n_fail++; $display("FAIL ooo_resp2: got v=%b tag=%0d data=%h expected 1 2 beef", resp_valid, resp_tag, resp_data);
    end
    tick(); tick();
    n_checks++;
    if ({resp_valid, resp_tag, outstanding} !== {1'b0, 2'd3, 3'd1}) begin
      n_fail++; $display("FAIL ooo_stall: got v=%b tag=%0d out=%0d expected 0 3 1", resp_valid, resp_tag, outstanding);
    end
    set_bank(1, 3, 16'hCAFE); tick(); clear_inputs();
    n_checks++;
    if ({resp_valid, resp_tag, resp_data} !== {1'b1, 2'd3, 16'hCAFE}) begin
      n_fail++; $display("FAIL ooo_resp3: got v=%b tag=%0d data=%h expected 1 3 cafe", resp_valid, resp_tag, resp_data);
    end
    tick();
    n_checks++;
    if ({outstanding, err_sticky} !== {3'd0, 1'b0}) begin
      n_fail++; $display("FAIL ooo_drain: got out=%0d err=%b expected 0 0", outstanding, err_sticky);
    end
  endtask

  task automatic test_mixed();
    resp_ready = 1'b1;
    issue_valid = 1'b1; issue_wen = 1'b0; tick();
    issue_wen = 1'b1; tick();
    clear_inputs();
    n_checks++;
    if ({resp_valid, outstanding} !== {1'b0, 3'd2}) begin
      n_fail++; $display("FAIL mixed_wait: got v=%b out=%0d expected 0 2", resp_valid, outstanding);
    end
    set_bank(1, 0, 16'h00A5); tick(); clear_inputs();
    n_checks++;
    if ({resp_valid, resp_tag, resp_data, resp_wen} !== {1'b1, 2'd0, 16'h00A5, 1'b0}) begin
      n_fail++; $display("FAIL mixed_read: got v=%b tag=%0d data=%h wen=%b expected 1 0 00a5 0", resp_valid, resp_tag, resp_data, resp_wen);
    end
    tick();
    n_checks++;
    if ({resp_valid, resp_tag, resp_data, resp_wen} !== {1'b1, 2'd1, 16'h0, 1'b1}) begin
      n_fail++; $display("FAIL mixed_wack: got v=%b tag=%0d data=%h wen=%b expected 1 1 0000 1", resp_valid, resp_tag, resp_data, resp_wen);
    end
    tick();
    n_checks++;
    if (outstanding !== 3'd0) begin
      n_fail++; $display("FAIL mixed_drain: got out=%0d expected 0", outstanding);
    end
  endtask

  task automatic test_backpressure_wrap();
    logic [TW-1:0] rtag;
    bit            wrap_seen;
    resp_ready = 1'b0;
    issue_valid = 1'b1; tick(); clear_inputs();
    set_bank(3, 2, 16'h7E57); tick(); clear_inputs();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({resp_valid, resp_tag, resp_data, resp_wen} !== {1'b1, 2'd2, 16'h7E57, 1'b0}) begin
        n_fail++; $display("FAIL bp_stable: cycle %0d got v=%b tag=%0d data=%h expected 1 2 7e57", i, resp_valid, resp_tag, resp_data);
      end
      tick();
    end
    resp_ready = 1'b1; tick();
    n_checks++;
    if (outstanding !== 3'd0) begin
      n_fail++; $display("FAIL bp_release: got out=%0d expected 0", outstanding);
    end
    wrap_seen = 1'b0;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 5; c++) begin
        clear_inputs();
        if (c == 0) begin issue_valid = 1'b1; issue_wen = 1'b1; end
        if (c == 1) begin issue_valid = 1'b1; issue_wen = 1'b0; rtag = issue_tag; end
        if (c == 2) set_bank($urandom_range(0, 3), int'(rtag), 16'($urandom));
        if (issue_valid && issue_tag == 2'd0 && (r > 0 || c > 0)) wrap_seen = 1'b1;
        tick();
        n_checks++;
        if ({resp_valid, resp_tag, resp_data, resp_wen, issue_tag} !==
            {ord_q.size() > 0 && m_done[ord_q[0]], TW'(m_head_tag),
             (ord_q.size() > 0 && m_done[ord_q[0]]) ? m_data[ord_q[0]] : 16'h0,
             ord_q.size() > 0 && m_done[ord_q[0]] && m_wen[ord_q[0]], TW'(m_tail_tag)}) begin
          n_fail++; $display("FAIL wrap_order: round %0d cycle %0d got v=%b tag=%0d data=%h wen=%b itag=%0d, model head=%0d tail=%0d",
                             r, c, resp_valid, resp_tag, resp_data, resp_wen, issue_tag, m_head_tag, m_tail_tag);
        end
      end
    end
    clear_inputs();
    n_checks++;
    if ({wrap_seen, outstanding} !== {1'b1, 3'd0}) begin
      n_fail++; $display("FAIL wrap_done: got wrap=%b out=%0d expected 1 0", wrap_seen, outstanding);
    end
  endtask

  task automatic test_errors();
    logic [TW-1:0] t0;
    resp_ready = 1'b1;
    t0 = issue_tag;
    set_bank(0, int'(t0 + 2'd1), 16'h1111); tick(); clear_inputs();
    n_checks++;
    if ({err_sticky, outstanding, resp_valid, issue_tag} !== {1'b1, 3'd0, 1'b0, t0}) begin
      n_fail++; $display("FAIL err_unalloc: got err=%b out=%0d v=%b itag=%0d expected 1 0 0 %0d", err_sticky, outstanding, resp_valid, issue_tag, t0);
    end
    err_clear = 1'b1; tick(); clear_inputs();
    n_checks++;
    if (err_sticky !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got err=%b expected 0", err_sticky);
    end
    resp_ready = 1'b0;
    issue_valid = 1'b1; tick(); clear_inputs();
    set_bank(1, int'(t0), 16'hAAAA); set_bank(2, int'(t0), 16'h5555); tick(); clear_inputs();
    n_checks++;
    if ({resp_valid, resp_tag, resp_data, err_sticky} !== {1'b1, t0, 16'hAAAA, 1'b1}) begin
      n_fail++; $display("FAIL err_dup: got v=%b tag=%0d data=%h err=%b expected 1 %0d aaaa 1", resp_valid, resp_tag, resp_data, err_sticky, t0);
    end
    err_clear = 1'b1; set_bank(0, int'(t0), 16'h2222); tick(); clear_inputs();
    n_checks++;
    if ({err_sticky, resp_data} !== {1'b1, 16'hAAAA}) begin
      n_fail++; $display("FAIL err_clear_vs_new: got err=%b data=%h expected 1 aaaa", err_sticky, resp_data);
    end
    err_clear = 1'b1; resp_ready = 1'b1; tick(); clear_inputs();
    n_checks++;
    if ({err_sticky, outstanding} !== {1'b0, 3'd0}) begin
      n_fail++; $display("FAIL err_final: got err=%b out=%0d expected 0 0", err_sticky, outstanding);
    end
  endtask

  task automatic test_full_retire();
    logic [TW-1:0] t0;
    resp_ready = 1'b0;
    t0 = issue_tag;
    for (int i = 0; i < 4; i++) begin issue_valid = 1'b1; issue_wen = 1'b1; tick(); end
    n_checks++;
    if ({outstanding, issue_ready, resp_valid} !== {3'd4, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL full_fill: got out=%0d ready=%b v=%b expected 4 0 1", outstanding, issue_ready, resp_valid);
    end
    resp_ready = 1'b1; tick();
    n_checks++;
    if ({outstanding, issue_ready, issue_tag} !== {3'd3, 1'b1, t0}) begin
      n_fail++; $display("FAIL full_reject: got out=%0d ready=%b itag=%0d expected 3 1 %0d", outstanding, issue_ready, issue_tag, t0);
    end
    resp_ready = 1'b0; tick(); clear_inputs();
    n_checks++;
    if ({outstanding, issue_tag} !== {3'd4, t0 + 2'd1}) begin
      n_fail++; $display("FAIL full_accept: got out=%0d itag=%0d expected 4 %0d", outstanding, issue_tag, t0 + 2'd1);
    end
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (outstanding !== 3'd0) begin
      n_fail++; $display("FAIL full_drain: got out=%0d expected 0", outstanding);
    end
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin issue_valid = 1'b1; issue_wen = 1'b0; tick(); end
    clear_inputs();
    n_checks++;
    if (outstanding !== 3'd3) begin
      n_fail++; $display("FAIL mid_pre: got out=%0d expected 3", outstanding);
    end
    reset = 1'b1; tick(); clear_inputs();
    n_checks++;
    if ({outstanding, resp_valid, issue_tag, err_sticky} !== {3'd0, 1'b0, 2'd0, 1'b0}) begin
      n_fail++; $display("FAIL mid_reset: got out=%0d v=%b itag=%0d err=%b expected 0 0 0 0", outstanding, resp_valid, issue_tag, err_sticky);
    end
    set_bank(2, 0, 16'h0BAD); tick(); clear_inputs();
    n_checks++;
    if ({err_sticky, resp_valid, outstanding} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL mid_late: got err=%b v=%b out=%0d expected 1 0 0", err_sticky, resp_valid, outstanding);
    end
  endtask

  task automatic test_random();
    bit e_rv;
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      issue_valid = ($urandom_range(0, 99) < 50);
      issue_wen   = ($urandom_range(0, 99) < 30);
      resp_ready  = ($urandom_range(0, 99) < 60);
      err_clear   = ($urandom_range(0, 99) < 5);
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 99) < 20) begin
          if (ord_q.size() > 0 && $urandom_range(0, 3) != 0)
            set_bank(b, ord_q[$urandom_range(0, ord_q.size() - 1)], 16'($urandom));
          else
            set_bank(b, $urandom_range(0, 3), 16'($urandom));
        end
      end
      tick();
      e_rv = ord_q.size() > 0 && m_done[ord_q[0]];
      n_checks++;
      if ({issue_ready, issue_tag, outstanding, resp_valid, resp_tag, resp_data, resp_wen, err_sticky} !==
          {ord_q.size() != 4, TW'(m_tail_tag), 3'(ord_q.size()), e_rv, TW'(m_head_tag),
           e_rv ? m_data[ord_q[0]] : 16'h0, e_rv && m_wen[ord_q[0]], m_err}) begin
        n_fail++; $display("FAIL random: cycle %0d got rdy=%b itag=%0d out=%0d v=%b tag=%0d data=%h wen=%b err=%b, model out=%0d head=%0d tail=%0d err=%b",
                           c, issue_ready, issue_tag, outstanding, resp_valid, resp_tag, resp_data, resp_wen, err_sticky,
                           ord_q.size(), m_head_tag, m_tail_tag, m_err);
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    resp_ready = 1'b1;
    m_tail_tag = 0; m_head_tag = 0; m_err = 1'b0;
    for (int i = 0; i < 4; i++) begin m_done[i] = 1'b0; m_wen[i] = 1'b0; m_data[i] = '0; end
    test_reset();
    test_ooo_reads();
    test_mixed();
    test_backpressure_wrap();
    test_errors();
    test_full_retire();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
